ibr128_stream_ctrl: RTL and testbench

//  Host-side initiator for IBR128_core: accepts a stream of 128-bit blocks, presents each to the core with the

---
 rtl/ibr128_stream_ctrl_if.sv | 8 +
 rtl/ibr128_stream_ctrl.sv | 99 +++++++++
 tb/tb_ibr128_stream_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ibr128_stream_ctrl_if.sv
// ibr128_stream_ctrl_if: valid/ready stream carrying one data block per transfer
interface ibr128_stream_ctrl_if #(parameter int W = 128);
  logic valid;
  logic ready;
  logic [W-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/ibr128_stream_ctrl.sv
// ibr128_stream_ctrl: streams 128-bit blocks through IBR128_core with OB framing and Enable handshaking
module ibr128_stream_ctrl #(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 16
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               start,
  input  logic               cfg_sa,
  input  logic               cfg_encrypt,
  input  logic [1:0]         cfg_som,
  input  logic [31:0]        cfg_iv,
  input  logic [63:0]        cfg_key0,
  input  logic [63:0]        cfg_key1,
  input  logic [CNT_W-1:0]   num_blocks,
  ibr128_stream_ctrl_if.slave  src,
  ibr128_stream_ctrl_if.master dst,
  output logic               busy,
  output logic               err_timeout,
  output logic               core_Enable,
  output logic               core_SA,
  output logic               core_Encrypt,
  output logic               core_OB,
  output logic [1:0]         core_SOM,
  output logic [31:0]        core_IV,
  output logic [63:0]        core_key0,
  output logic [63:0]        core_key1,
  output logic [127:0]       core_plainText,
  input  logic [127:0]       core_cipherText,
  input  logic               core_cipherReady
);
  localparam int TW = $clog2((TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr;
  logic [CNT_W-1:0] cnt, nb;
  logic go, ld, rdy, tout, acc, last, gap_done;
  // Enable and OB are pure state decodes so an async reset drops Enable and raises OB at once
  assign busy        = state != IDLE;
  assign core_OB     = state == IDLE;
  assign core_Enable = state == RUN;
  assign src.ready   = state == LOAD;
  assign dst.valid   = state == HOLD;
  assign go       = state == IDLE && start;
  assign ld       = state == LOAD && src.valid;
  assign rdy      = state == RUN && core_cipherReady;
  assign tout     = state == RUN && !core_cipherReady && tmr == TW'(TIMEOUT - 1);
  assign acc      = state == HOLD && dst.ready;
  assign last     = CNT_W'(cnt + 1'b1) == nb;
  assign gap_done = tmr == TW'(GAP_CYCLES - 1);
  // State register
  always_ff @(posedge Clk or negedge RstN)
    if (!RstN) state <= IDLE;
    else state <= state_n;
  // Next-state: one block per LOAD/RUN/HOLD pass, GAP spaces blocks, timeout aborts the message
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = src.valid ? RUN : LOAD;
      RUN:     state_n = core_cipherReady ? HOLD : tout ? IDLE : RUN;
      HOLD:    state_n = dst.ready ? (last ? IDLE : GAP) : HOLD;
      GAP:     state_n = gap_done ? LOAD : GAP;
      default: state_n = IDLE;
    endcase
  end
  // Cycle timer restarts on every state change; bounds RUN and times GAP
  always_ff @(posedge Clk or negedge RstN)
    if (!RstN) tmr <= '0;
    else tmr <= state_n != state ? '0 : tmr + 1'b1;
  // Message config, block counter and sticky timeout flag
  always_ff @(posedge Clk or negedge RstN)
    if (!RstN) begin
      {core_SA, core_Encrypt, core_SOM, core_IV, core_key0, core_key1} <= '0;
      nb <= '0;
      cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (go) begin
        {core_SA, core_Encrypt, core_SOM, core_IV} <= {cfg_sa, cfg_encrypt, cfg_som, cfg_iv};
        {core_key0, core_key1} <= {cfg_key0, cfg_key1};
        nb <= num_blocks == '0 ? CNT_W'(1) : num_blocks;
        cnt <= '0;
        err_timeout <= 1'b0;
      end
      if (acc) cnt <= cnt + 1'b1;
      if (tout) err_timeout <= 1'b1;
    end
  // Block data: input block held for the core, core result held for the output stream
  always_ff @(posedge Clk or negedge RstN)
    if (!RstN) begin
      core_plainText <= '0;
      dst.data <= '0;
    end else begin
      if (ld) core_plainText <= src.data;
      if (rdy) dst.data <= core_cipherText;
    end
endmodule

// File: tb/tb_ibr128_stream_ctrl.sv
// tb_ibr128_stream_ctrl: directed vectors plus corner sequences against a behavioural core model
module tb_ibr128_stream_ctrl;
  localparam int GAP = 2;
  localparam int TMO = 40;
  logic Clk = 1'b0, RstN = 1'b0, start = 1'b0;
  logic cfg_sa = 1'b0, cfg_encrypt = 1'b0;
  logic [1:0] cfg_som = '0;
  logic [31:0] cfg_iv = '0;
  logic [63:0] cfg_key0 = '0, cfg_key1 = '0;
  logic [15:0] num_blocks = '0;
  logic busy, err_timeout, core_Enable, core_SA, core_Encrypt, core_OB;
  logic [1:0] core_SOM;
  logic [31:0] core_IV;
  logic [63:0] core_key0, core_key1;
  logic [127:0] core_plainText, c_txt;
  logic c_rdy, mute = 1'b0;
  int c_cnt;
  int checks = 0, failures = 0;
  int ob_viol = 0, en_viol = 0, min_gap = 1000, low = 0, en_hi = 0, ov_cnt = 0;
  logic seen = 1'b0;
  ibr128_stream_ctrl_if src_if ();
  ibr128_stream_ctrl_if dst_if ();
  ibr128_stream_ctrl #(.GAP_CYCLES(GAP), .TIMEOUT(TMO), .CNT_W(16)) dut (
    .Clk(Clk), .RstN(RstN), .start(start), .cfg_sa(cfg_sa), .cfg_encrypt(cfg_encrypt),
    .cfg_som(cfg_som), .cfg_iv(cfg_iv), .cfg_key0(cfg_key0), .cfg_key1(cfg_key1),
    .num_blocks(num_blocks), .src(src_if), .dst(dst_if), .busy(busy), .err_timeout(err_timeout),
    .core_Enable(core_Enable), .core_SA(core_SA), .core_Encrypt(core_Encrypt), .core_OB(core_OB),
    .core_SOM(core_SOM), .core_IV(core_IV), .core_key0(core_key0), .core_key1(core_key1),
    .core_plainText(core_plainText), .core_cipherText(c_txt), .core_cipherReady(c_rdy)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic sa, enc;
    logic [1:0] som;
    logic [31:0] iv;
    logic [63:0] k0, k1;
    logic [15:0] nb;
    int nblk;
    logic [127:0] d0, d1;
  } vec_t;
  vec_t vt[3];
  function automatic logic [127:0] core_fn(logic [127:0] pt, logic [63:0] k1, logic [63:0] k0,
                                           logic [31:0] iv, logic [1:0] som, logic enc, logic sa);
    return {pt[63:0], pt[127:64]} ^ {k1, k0} ^ {4{iv}} ^ {124'd0, som, enc, sa};
  endfunction
  // Core model: answers after three Enable-high cycles unless muted
  always @(posedge Clk or negedge RstN)
    if (!RstN) begin
      c_rdy <= 1'b0; c_cnt <= 0; c_txt <= '0;
    end else if (c_rdy) begin
      c_rdy <= 1'b0; c_cnt <= 0;
    end else if (core_Enable && !mute) begin
      if (c_cnt == 2) begin
        c_rdy <= 1'b1;
        c_txt <= core_fn(core_plainText, core_key1, core_key0, core_IV, core_SOM, core_Encrypt, core_SA);
      end else c_cnt <= c_cnt + 1;
    end else c_cnt <= 0;
  // Protocol monitor: OB framing, Enable exclusivity, Enable-low gaps inside a message
  always @(negedge Clk) begin
    if (core_OB !== !busy) ob_viol++;
    if (core_Enable && (src_if.ready || dst_if.valid || !busy)) en_viol++;
    if (dst_if.valid) ov_cnt++;
    if (core_Enable) begin
      if (seen && low > 0 && low < min_gap) min_gap = low;
      low = 0; seen = 1'b1; en_hi++;
    end else low++;
    if (!busy) seen = 1'b0;
  end
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic do_start(vec_t v);
    {cfg_sa, cfg_encrypt, cfg_som, cfg_iv} = {v.sa, v.enc, v.som, v.iv};
    {cfg_key0, cfg_key1, num_blocks} = {v.k0, v.k1, v.nb};
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask
  task automatic send(logic [127:0] d);
    int n = 0;
    src_if.valid = 1'b1;
    src_if.data = d;
    while (!src_if.ready && n < 50) begin @(negedge Clk); n++; end
    chk("in_ready_wait", 128'(src_if.ready), 1);
    @(negedge Clk);
    src_if.valid = 1'b0;
  endtask
  task automatic recv(string nm, logic [127:0] exp, int stall);
    int n = 0;
    dst_if.ready = stall == 0;
    while (!dst_if.valid && n < 200) begin @(negedge Clk); n++; end
    chk({nm, "_valid_wait"}, 128'(dst_if.valid), 1);
    for (int i = 0; i < stall; i++) begin
      chk({nm, "_stall_data"}, dst_if.data, exp);
      chk({nm, "_stall_enable"}, 128'(core_Enable), 0);
      chk({nm, "_stall_in_ready"}, 128'(src_if.ready), 0);
      @(negedge Clk);
    end
    dst_if.ready = 1'b1;
    chk({nm, "_data"}, dst_if.data, exp);
    chk({nm, "_ob_at_accept"}, 128'(core_OB), 0);
    @(negedge Clk);
    dst_if.ready = 1'b0;
  endtask
  task automatic run_vec(string nm, vec_t v, int stall);
    do_start(v);
    chk({nm, "_busy"}, 128'(busy), 1);
    chk({nm, "_ob_load"}, 128'(core_OB), 0);
    chk({nm, "_err_clear"}, 128'(err_timeout), 0);
    send(v.d0);
    recv({nm, "_b0"}, core_fn(v.d0, v.k1, v.k0, v.iv, v.som, v.enc, v.sa), stall);
    if (v.nblk > 1) begin
      chk({nm, "_ob_gap"}, 128'(core_OB), 0);
      send(v.d1);
      recv({nm, "_b1"}, core_fn(v.d1, v.k1, v.k0, v.iv, v.som, v.enc, v.sa), stall);
    end
    chk({nm, "_ob_end"}, 128'(core_OB), 1);
    chk({nm, "_busy_end"}, 128'(busy), 0);
  endtask
  initial begin
    int e0, o0, n;
    vt[0] = '{1'b0, 1'b1, 2'd3, 32'h1111_1111, 64'h9988_1234_5670_1122, 64'haabb_0918_2736_ccdd,
              16'd1, 1, 128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536, 128'h0};
    vt[1] = '{1'b0, 1'b1, 2'd3, 32'h1111_1111, 64'h9988_1234_5670_1122, 64'haabb_0918_2736_ccdd,
              16'd2, 2, 128'h1234_56ab_cd13_2536_1234_56ab_cd13_2536,
              128'h3456_7891_2351_6610_4309_acdf_ec12_ba22};
    vt[2] = '{1'b1, 1'b0, 2'd2, 32'hdead_beef, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
              16'd0, 1, 128'hcafe_f00d_0000_ffff_5a5a_a5a5_0f0f_f0f0, 128'h0};
    src_if.valid = 1'b0;
    src_if.data = '0;
    dst_if.ready = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_ob", 128'(core_OB), 1);
    chk("rst_enable", 128'(core_Enable), 0);
    chk("rst_in_ready", 128'(src_if.ready), 0);
    chk("rst_out_valid", 128'(dst_if.valid), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_err", 128'(err_timeout), 0);
    RstN = 1'b1;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) run_vec($sformatf("vec%0d", i), vt[i], 0);
    run_vec("backpressure", vt[0], 10);
    mute = 1'b1;
    e0 = en_hi;
    o0 = ov_cnt;
    do_start(vt[0]);
    send(vt[0].d0);
    n = 0;
    while (busy && n < TMO + 50) begin @(negedge Clk); n++; end
    chk("tmo_idle", 128'(busy), 0);
    chk("tmo_err", 128'(err_timeout), 1);
    chk("tmo_ob", 128'(core_OB), 1);
    chk("tmo_enable_cycles", 128'(en_hi - e0), TMO);
    chk("tmo_no_output", 128'(ov_cnt - o0), 0);
    mute = 1'b0;
    run_vec("after_tmo", vt[2], 0);
    mute = 1'b1;
    do_start(vt[2]);
    send(vt[2].d0);
    chk("rst_run_enable_before", 128'(core_Enable), 1);
    #2 RstN = 1'b0;
    #1;
    chk("rst_run_enable", 128'(core_Enable), 0);
    chk("rst_run_ob", 128'(core_OB), 1);
    chk("rst_run_busy", 128'(busy), 0);
    chk("rst_run_in_ready", 128'(src_if.ready), 0);
    @(negedge Clk);
    RstN = 1'b1;
    mute = 1'b0;
    @(negedge Clk);
    run_vec("after_rst", vt[1], 0);
    chk("ob_busy_violations", 128'(ob_viol), 0);
    chk("enable_state_violations", 128'(en_viol), 0);
    chk("min_enable_gap", 128'(min_gap), GAP + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
